// File: rtl/mchan_ctrl_init_if.sv
// mchan_ctrl_init_if -- request/response bus from the MCHAN control initiator
// to the DMA command/status ports.
//   req/typ/be/add/data/id : request and its fields (typ 1 = read, 0 = write)
//   gnt                    : request accepted this cycle
//   r_valid/r_data/r_id    : response
// Modports: master = initiator (mchan_ctrl_init), slave = DMA side / model.
interface mchan_ctrl_init_if #(
    parameter int PE_ID_WIDTH = 1
);
    logic                   req;
    logic                   typ;
    logic [3:0]             be;
    logic [31:0]            add;
    logic [31:0]            data;
    logic [PE_ID_WIDTH-1:0] id;
    logic                   gnt;
    logic                   r_valid;
    logic [31:0]            r_data;
    logic [PE_ID_WIDTH-1:0] r_id;

    modport master (
        output req, typ, be, add, data, id,
        input  gnt, r_valid, r_data, r_id
    );

    modport slave (
        input  req, typ, be, add, data, id,
        output gnt, r_valid, r_data, r_id
    );
endinterface

// File: rtl/mchan_ctrl_init.sv
// mchan_ctrl_init -- turns one descriptor into the MCHAN command sequence:
// read a SID, write cmd word / TCDM addr / ext addr / optional 2D word,
// optionally poll the status port until the SID is idle and clear it, then
// pulse done_o with the SID.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   desc_*                : descriptor valid/ready handshake and fields
//   ctrl_init             : request/response bus (mchan_ctrl_init_if.master)
//   done_o, done_sid_o    : completion pulse and SID (SID held until next done)
//   err_o                 : poll timeout pulse (coincides with done_o)
//   busy_o                : not idle
// Build option: define MCHAN_CTRL_INIT_TIMEOUT_EN to bound POLL by
// TIMEOUT_CYCLES; otherwise POLL is unbounded and err_o is 0.
module mchan_ctrl_init #(
    parameter int          NB_TRANSFERS   = 4,
    parameter int          PE_ID_WIDTH    = 1,
    parameter int          PE_ID          = 0,
    parameter logic [31:0] CMD_ADD        = 32'h0000_0000,
    parameter logic [31:0] STATUS_ADD     = 32'h0000_0004,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int         SID_W          = (NB_TRANSFERS > 1) ? $clog2(NB_TRANSFERS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    input  logic [15:0]       desc_len_i,
    input  logic              desc_opc_i,
    input  logic              desc_inc_i,
    input  logic              desc_twd_i,
    input  logic              desc_wait_i,
    input  logic [31:0]       desc_tcdm_add_i,
    input  logic [31:0]       desc_ext_add_i,
    input  logic [31:0]       desc_twd_dat_i,
    mchan_ctrl_init_if.master ctrl_init,
    output logic              done_o,
    output logic [SID_W-1:0]  done_sid_o,
    output logic              err_o,
    output logic              busy_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_GET_SID, S_CMD, S_TCDM, S_EXT, S_TWD, S_POLL, S_CLEAR, S_DONE
    } state_e;

    state_e           state, state_nxt;
    // pend: current request granted, its response not yet seen
    logic             pend, pend_nxt;
    logic             rsp, sid_ld, tmo_hit, tmo_exit;
    logic             req, typ;
    logic [31:0]      add, data;

    logic [15:0]      len_q;
    logic             opc_q, inc_q, twd_q, wait_q;
    logic [31:0]      tcdm_q, ext_q, twd_dat_q;
    logic [SID_W-1:0] sid, done_sid;

    // Responses only count while one is owed and carry our ID; anything else
    // (foreign IDs, stale responses after reset) falls through.
    assign rsp = pend && ctrl_init.r_valid && (ctrl_init.r_id == PE_ID_WIDTH'(PE_ID));

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        req          = 1'b0;
        typ          = 1'b0;
        add          = '0;
        data         = '0;
        desc_ready_o = 1'b0;
        sid_ld       = 1'b0;
        tmo_exit     = 1'b0;

        // Request is a function of registered state only, so it and its
        // fields stay put however long gnt takes.
        if (state != S_IDLE && state != S_DONE) begin
            req = !pend;
            if (!pend && ctrl_init.gnt) pend_nxt = 1'b1;
            if (rsp)                    pend_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) state_nxt = S_GET_SID;
            end
            S_GET_SID: begin
                typ = 1'b1;
                add = CMD_ADD;
                if (rsp) begin
                    sid_ld    = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                add = CMD_ADD;
                data = {13'b0, twd_q, inc_q, opc_q, len_q};
                if (rsp) state_nxt = S_TCDM;
            end
            S_TCDM: begin
                add  = CMD_ADD;
                data = tcdm_q;
                if (rsp) state_nxt = S_EXT;
            end
            S_EXT: begin
                add  = CMD_ADD;
                data = ext_q;
                if (rsp) state_nxt = twd_q ? S_TWD : (wait_q ? S_POLL : S_DONE);
            end
            S_TWD: begin
                add  = CMD_ADD;
                data = twd_dat_q;
                if (rsp) state_nxt = wait_q ? S_POLL : S_DONE;
            end
            S_POLL: begin
                typ = 1'b1;
                add = STATUS_ADD;
                // Timeout is only acted on at a response so a request in
                // flight is never withdrawn; a busy SID just re-polls.
                if (rsp) begin
                    if (!ctrl_init.r_data[sid]) begin
                        state_nxt = S_CLEAR;
                    end else if (tmo_hit) begin
                        tmo_exit  = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                add  = STATUS_ADD;
                data = 32'(1) << sid;
                if (rsp) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            pend     <= 1'b0;
            sid      <= '0;
            done_sid <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            if (sid_ld)              sid      <= ctrl_init.r_data[SID_W-1:0];
            if (state_nxt == S_DONE) done_sid <= sid;
        end
    end

    // Descriptor fields are pure datapath; only loaded on acceptance.
    always_ff @(posedge clk_i) begin
        if (state == S_IDLE && desc_valid_i) begin
            len_q     <= desc_len_i;
            opc_q     <= desc_opc_i;
            inc_q     <= desc_inc_i;
            twd_q     <= desc_twd_i;
            wait_q    <= desc_wait_i;
            tcdm_q    <= desc_tcdm_add_i;
            ext_q     <= desc_ext_add_i;
            twd_dat_q <= desc_twd_dat_i;
        end
    end

`ifdef MCHAN_CTRL_INIT_TIMEOUT_EN
    logic [31:0] poll_cnt;
    logic        err_q;

    // Counts cycles spent in POLL, saturating; cleared whenever we leave.
    always_ff @(posedge clk_i) begin
        if (rst_i || state != S_POLL) poll_cnt <= '0;
        else if (poll_cnt != '1)      poll_cnt <= poll_cnt + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= tmo_exit;
    end

    assign tmo_hit = (poll_cnt >= 32'(TIMEOUT_CYCLES));
    assign err_o   = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0) ^ tmo_exit;
    assign tmo_hit    = 1'b0;
    assign err_o      = 1'b0;
`endif

    assign ctrl_init.req  = req;
    assign ctrl_init.typ  = typ;
    assign ctrl_init.be   = 4'hF;
    assign ctrl_init.add  = add;
    assign ctrl_init.data = data;
    assign ctrl_init.id   = PE_ID_WIDTH'(PE_ID);

    assign done_o     = (state == S_DONE);
    assign done_sid_o = done_sid;
    assign busy_o     = (state != S_IDLE);
endmodule

// File: tb/tb_mchan_ctrl_init.sv
// tb_mchan_ctrl_init -- random descriptors against a transaction-list model.
// The model expands each descriptor into the ordered list of bus accesses it
// must produce (with the read data the DMA side returns); a bus responder
// with random grant/response delays and foreign-ID noise pops that list.
`timescale 1ns/1ps
module tb_mchan_ctrl_init;
    localparam int          NB   = 4;
    localparam int          SW   = 2;
    localparam logic [0:0]  PEID = 1'b0;
    localparam logic [31:0] CMD  = 32'h0000_0000;
    localparam logic [31:0] STAT = 32'h0000_0004;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid, desc_ready;
    logic [15:0] desc_len;
    logic        desc_opc, desc_inc, desc_twd, desc_wait;
    logic [31:0] desc_tcdm, desc_ext, desc_twd_dat;
    logic        done, err, busy;
    logic [SW-1:0] done_sid;

    always #5 clk = ~clk;

    mchan_ctrl_init_if #(.PE_ID_WIDTH(1)) bus ();

    mchan_ctrl_init #(
        .NB_TRANSFERS(NB), .PE_ID_WIDTH(1), .PE_ID(0),
        .CMD_ADD(CMD), .STATUS_ADD(STAT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .desc_len_i(desc_len), .desc_opc_i(desc_opc), .desc_inc_i(desc_inc),
        .desc_twd_i(desc_twd), .desc_wait_i(desc_wait),
        .desc_tcdm_add_i(desc_tcdm), .desc_ext_add_i(desc_ext),
        .desc_twd_dat_i(desc_twd_dat),
        .ctrl_init(bus),
        .done_o(done), .done_sid_o(done_sid), .err_o(err), .busy_o(busy)
    );

    typedef struct {
        logic [15:0] len;
        logic        opc, inc, twd, wt;
        logic [31:0] tcdm, ext, twd_dat;
    } desc_t;

    typedef struct {
        logic        typ;
        logic [31:0] add, data, rdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_chk = 0, n_pass = 0;
    int   n_extra = 0, n_polls = 0;
    bit   stuck_mode = 0;
    int   force_gdly = -1, rdly_fix = 0;
    int   txn_idx = 0, stall_len = 0;
    int   gwait = -1, rcnt = 0, hold_cnt = 0;
    logic [31:0] rdat, last_add, hold_add, hold_data;
    logic        hold_typ;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- model: descriptor -> expected bus accesses -----------
    // npoll < 0: status never clears (timeout scenario), no polls listed.
    task automatic build_exp(input desc_t d, input int sid, input int npoll);
        logic [31:0] bit_s;
        bit_s = 32'(1) << sid;
        exp_q.delete();
        n_extra = 0; n_polls = 0; txn_idx = 0;
        exp_q.push_back('{1'b1, CMD, 32'h0, ($urandom << SW) | 32'(sid)});
        exp_q.push_back('{1'b0, CMD, {13'b0, d.twd, d.inc, d.opc, d.len}, $urandom});
        exp_q.push_back('{1'b0, CMD, d.tcdm, $urandom});
        exp_q.push_back('{1'b0, CMD, d.ext, $urandom});
        if (d.twd) exp_q.push_back('{1'b0, CMD, d.twd_dat, $urandom});
        if (d.wt && npoll >= 0) begin
            for (int i = 0; i < npoll; i++)
                exp_q.push_back('{1'b1, STAT, 32'h0, $urandom | bit_s});
            exp_q.push_back('{1'b1, STAT, 32'h0, $urandom & ~bit_s});
            exp_q.push_back('{1'b0, STAT, bit_s, $urandom});
        end
    endtask

    // ---------------- bus responder -----------------------------------------
    task automatic take_txn();
        txn_t e;
        last_add = bus.add;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("txn_type", 32'(bus.typ), 32'(e.typ));
            chk("txn_add", bus.add, e.add);
            chk("txn_data", bus.data, e.data);
            rdat = e.rdata;
        end else if (stuck_mode && bus.typ && bus.add == STAT) begin
            n_polls++;
            rdat = 32'hF;
        end else begin
            n_extra++;
            rdat = $urandom;
        end
    endtask

    initial begin
        bus.gnt = 0; bus.r_valid = 0; bus.r_data = 0; bus.r_id = PEID;
        forever begin
            @(negedge clk);
            bus.gnt = 0; bus.r_valid = 0; bus.r_id = PEID; bus.r_data = $urandom;
            if (rcnt > 0) begin
                chk("one_outstanding", 32'(bus.req), 32'd0);
                rcnt--;
                if (rcnt == 0) begin
                    bus.r_valid = 1; bus.r_data = rdat;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.r_valid = 1; bus.r_id = ~PEID;   // foreign response noise
                end
            end else if (!rst && (bus.req || gwait >= 0)) begin
                if (gwait < 0) begin
                    gwait = (force_gdly >= 0 && txn_idx == 1) ? force_gdly : $urandom_range(0, 2);
                    hold_add = bus.add; hold_data = bus.data; hold_typ = bus.typ; hold_cnt = 1;
                end else begin
                    hold_cnt++;
                    chk("req_held", 32'(bus.req), 32'd1);
                    chk("add_stable", bus.add, hold_add);
                    chk("data_stable", bus.data, hold_data);
                    chk("type_stable", 32'(bus.typ), 32'(hold_typ));
                end
                if (gwait == 0) begin
                    bus.gnt = 1;
                    if (force_gdly >= 0 && txn_idx == 1) stall_len = hold_cnt;
                    txn_idx++;
                    gwait = -1;
                    rcnt  = (rdly_fix > 0) ? rdly_fix : 1 + $urandom_range(0, 2);
                    take_txn();
                end else begin
                    gwait--;
                end
            end
        end
    end

    // ---------------- descriptor driver -------------------------------------
    function automatic desc_t rand_desc();
        desc_t d;
        d.len = 16'($urandom); d.opc = 1'($urandom); d.inc = 1'($urandom);
        d.twd = 1'($urandom); d.wt = 1'($urandom);
        d.tcdm = $urandom; d.ext = $urandom; d.twd_dat = $urandom;
        return d;
    endfunction

    task automatic offer(input desc_t d);
        @(negedge clk); #1;
        chk("ready_idle", 32'(desc_ready), 32'd1);
        desc_len = d.len; desc_opc = d.opc; desc_inc = d.inc; desc_twd = d.twd;
        desc_wait = d.wt; desc_tcdm = d.tcdm; desc_ext = d.ext; desc_twd_dat = d.twd_dat;
        desc_valid = 1;
        @(negedge clk); #1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        // keep offering junk while busy; it must not be taken
        desc_len = 16'($urandom); desc_tcdm = $urandom; desc_ext = $urandom;
        desc_twd = 1'($urandom); desc_wait = 1'($urandom);
        @(negedge clk); #1;
        chk("ready_busy", 32'(desc_ready), 32'd0);
        desc_valid = 0;
    endtask

    task automatic wait_done(input int sid, input logic exp_err);
        int i = 0;
        while (i < 3000 && done !== 1'b1) begin @(negedge clk); #1; i++; end
        chk("done_seen", 32'(done), 32'd1);
        chk("done_sid", 32'(done_sid), 32'(sid));
        chk("err_at_done", 32'(err), 32'(exp_err));
        chk("txn_left", 32'(exp_q.size()), 32'd0);
        chk("extra_txn", 32'(n_extra), 32'd0);
        @(negedge clk); #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("sid_hold", 32'(done_sid), 32'(sid));
        chk("err_pulse", 32'(err), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic run(input desc_t d, input int sid, input int npoll);
        build_exp(d, sid, npoll);
        offer(d);
        wait_done(sid, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req"}, 32'(bus.req), 32'd0);
        chk({tag, "_type"}, 32'(bus.typ), 32'd0);
        chk({tag, "_be"}, 32'(bus.be), 32'hF);
        chk({tag, "_add"}, bus.add, 32'd0);
        chk({tag, "_data"}, bus.data, 32'd0);
        chk({tag, "_id"}, 32'(bus.id), 32'(PEID));
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_done_sid"}, 32'(done_sid), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(desc_ready), 32'd1);
    endtask

    initial begin
        desc_t d;
        int    sid, i;
        rst = 1; desc_valid = 0;
        desc_len = 0; desc_opc = 0; desc_inc = 0; desc_twd = 0; desc_wait = 0;
        desc_tcdm = 0; desc_ext = 0; desc_twd_dat = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset");
        rst = 0;

        // basic 1D transfer, SID 2
        d = '{16'd64, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0040, 32'h8000_0100, 32'h0};
        run(d, 2, 0);

        // 2D + wait: two busy polls then idle, clear SID 2
        d = '{16'd128, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1000_0200, 32'h8000_0400, 32'h0010_0008};
        run(d, 2, 2);

        // CMD write grant held off 5 cycles: request must stay stable for 6
        force_gdly = 5; stall_len = 0;
        run(rand_desc(), 1, 1);
        chk("gnt_stall_len", 32'(stall_len), 32'd6);
        force_gdly = -1;

        // reset while a status poll response is outstanding
        d = rand_desc(); d.twd = 0; d.wt = 1;
        rdly_fix = 4;
        build_exp(d, 3, 30);
        offer(d);
        i = 0;
        while (i < 2000 && !(rcnt >= 3 && last_add == STAT)) begin @(negedge clk); #1; i++; end
        chk("poll_reached", last_add, STAT);
        rst = 1;
        @(negedge clk); #1;
        rst = 0;
        check_reset_state("rst_mid");
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk("rst_no_done", 32'(done), 32'd0);
            chk("rst_stay_idle", 32'(busy), 32'd0);
        end
        chk("rst_late_rsp_gone", 32'(rcnt), 32'd0);
        rdly_fix = 0;

        // random descriptors
        for (int n = 0; n < 25; n++) begin
            sid = $urandom_range(0, NB - 1);
            run(rand_desc(), sid, $urandom_range(0, 3));
        end

`ifdef MCHAN_CTRL_INIT_TIMEOUT_EN
        // status stuck at 0xF: timeout, no CLEAR, err with done
        d = rand_desc(); d.twd = 0; d.wt = 1;
        build_exp(d, 2, -1);
        stuck_mode = 1;
        offer(d);
        wait_done(2, 1'b1);
        chk("tmo_polled", 32'(n_polls > 1), 32'd1);
        stuck_mode = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
